// File: rtl/hazard_pkg.sv
// Shared encodings for the LEGv8 forwarding/hazard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10,
        FWD_MC    = 2'b11
    } fwd_sel_e;

    localparam int ZERO_REG_DEF = 31;

endpackage

// File: rtl/fwd_operand_sel.sv
// Forward-select priority decode for a single EX-stage source operand.
module fwd_operand_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic              branching,
    input  logic [REG_AW-1:0] src,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              mc_done,
    input  logic [REG_AW-1:0] mc_dst,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    fwd_sel_e sel_s;

    // Youngest producer wins; XZR and branch resolution always read the regfile path.
    always_comb begin
        sel_s = FWD_REG;
        if (branching || (src == ZR)) begin
            sel_s = FWD_REG;
        end else if (exmem_regwrite && (exmem_rd == src)) begin
            sel_s = FWD_EXMEM;
        end else if (mc_done && (mc_dst == src)) begin
            sel_s = FWD_MC;
        end else if (memwb_regwrite && (memwb_rd == src)) begin
            sel_s = FWD_MEMWB;
        end else begin
            sel_s = FWD_REG;
        end
    end

    assign sel = sel_s;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding, load-use / multi-cycle hazard detection and stall perf counter
// for the 5-stage LEGv8 pipeline.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MC_LAT   = 4,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      branching,
    input  logic [NUM_SRC*REG_AW-1:0] idex_src,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_valid,
    input  logic                      idex_memread,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      exmem_regwrite,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      memwb_regwrite,
    input  logic [REG_AW-1:0]         memwb_rd,
    input  logic                      mc_issue,
    input  logic [REG_AW-1:0]         mc_rd,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      mc_busy,
    output logic                      mc_done,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int                CW      = $clog2(MC_LAT);
    localparam logic [CW-1:0]     MC_INIT = CW'(MC_LAT - 1);
    localparam logic [REG_AW-1:0] ZR      = REG_AW'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [CW-1:0]     mc_cnt_r, mc_cnt_nx_s;
    logic              mc_busy_r, mc_busy_nx_s;
    logic              mc_done_r, mc_done_nx_s;
    logic [REG_AW-1:0] mc_dst_r, mc_dst_nx_s;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic              load_use_s, mc_raw_s, mc_struct_s, stall_s, issue_ok_s;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_operand_sel #(
            .REG_AW   (REG_AW),
            .ZERO_REG (ZERO_REG)
        ) u_sel (
            .branching      (branching),
            .src            (idex_src[k*REG_AW +: REG_AW]),
            .exmem_regwrite (exmem_regwrite),
            .exmem_rd       (exmem_rd),
            .mc_done        (mc_done_r),
            .mc_dst         (mc_dst_r),
            .memwb_regwrite (memwb_regwrite),
            .memwb_rd       (memwb_rd),
            .sel            (fwd_sel[2*k +: 2])
        );
    end

    // Hazard OR-tree over the valid ID-stage operands.
    always_comb begin
        load_use_s = 1'b0;
        mc_raw_s   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            load_use_s = load_use_s | (id_src_valid[k] & idex_memread & (idex_rd != ZR)
                                       & (id_src[k*REG_AW +: REG_AW] == idex_rd));
            mc_raw_s   = mc_raw_s | (id_src_valid[k] & mc_busy_r & ~mc_done_r & (mc_dst_r != ZR)
                                     & (id_src[k*REG_AW +: REG_AW] == mc_dst_r));
        end
        mc_struct_s = mc_issue & mc_busy_r & ~mc_done_r;
        stall_s     = load_use_s | mc_raw_s | mc_struct_s;
        issue_ok_s  = mc_issue & ~stall_s;
    end

    // Scoreboard next state; an issue accepted in the done cycle overrides the clear.
    always_comb begin
        mc_busy_nx_s = mc_busy_r;
        mc_cnt_nx_s  = mc_cnt_r;
        mc_dst_nx_s  = mc_dst_r;
        if (issue_ok_s) begin
            mc_busy_nx_s = 1'b1;
            mc_cnt_nx_s  = MC_INIT;
            mc_dst_nx_s  = mc_rd;
        end else if (mc_busy_r && (mc_cnt_r == {CW{1'b0}})) begin
            mc_busy_nx_s = 1'b0;
            mc_cnt_nx_s  = {CW{1'b0}};
        end else if (mc_busy_r) begin
            mc_cnt_nx_s  = mc_cnt_r - CW'(1);
        end else begin
            mc_cnt_nx_s  = mc_cnt_r;
        end
        mc_done_nx_s = mc_busy_nx_s & (mc_cnt_nx_s == {CW{1'b0}});
    end

    // State registers: scoreboard and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_busy_r      <= 1'b0;
            mc_done_r      <= 1'b0;
            mc_cnt_r       <= {CW{1'b0}};
            mc_dst_r       <= {REG_AW{1'b0}};
            stall_cycles_r <= {CNT_W{1'b0}};
        end else begin
            mc_busy_r <= mc_busy_nx_s;
            mc_done_r <= mc_done_nx_s;
            mc_cnt_r  <= mc_cnt_nx_s;
            mc_dst_r  <= mc_dst_nx_s;
            if (stall_s && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    assign stall        = stall_s;
    assign mc_busy      = mc_busy_r;
    assign mc_done      = mc_done_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed vector table plus multi-cycle sequences for hazard_forward_unit.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        branching;
    logic [9:0]  idex_src, id_src;
    logic [1:0]  id_src_valid;
    logic        idex_memread;
    logic [4:0]  idex_rd;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic        mc_issue;
    logic [4:0]  mc_rd;
    logic [3:0]  fwd_sel;
    logic        stall, mc_busy, mc_done;
    logic [3:0]  stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_AW(5), .NUM_SRC(2), .MC_LAT(4), .ZERO_REG(31), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .branching(branching),
        .idex_src(idex_src), .id_src(id_src), .id_src_valid(id_src_valid),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .mc_issue(mc_issue), .mc_rd(mc_rd),
        .fwd_sel(fwd_sel), .stall(stall), .mc_busy(mc_busy),
        .mc_done(mc_done), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic       br;
        logic [4:0] xs0, xs1, is0, is1;
        logic [1:0] iv;
        logic       mr;
        logic [4:0] xrd;
        logic       ew;
        logic [4:0] erd;
        logic       mw;
        logic [4:0] mrd;
        logic [3:0] efwd;
        logic       es;
    } vec_t;

    vec_t tv[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        branching = 1'b0; idex_src = 10'd0; id_src = 10'd0; id_src_valid = 2'b00;
        idex_memread = 1'b0; idex_rd = 5'd0; exmem_regwrite = 1'b0; exmem_rd = 5'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0; mc_issue = 1'b0; mc_rd = 5'd0;
    endtask

    // Leaves the bench in "cycle 0": just past a clock edge with reset released.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic seen_done;
        logic seen_busy;

        //          br  xs0  xs1  is0  is1  iv     mr  xrd  ew  erd  mw  mrd  efwd     es
        tv[0]  = '{1'b0,5'd3, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b1,5'd3, 1'b1,5'd3, 4'b0010,1'b0};
        tv[1]  = '{1'b0,5'd3, 5'd0, 5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b0,5'd3, 1'b1,5'd3, 4'b0001,1'b0};
        tv[2]  = '{1'b0,5'd4, 5'd31,5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b1,5'd31,1'b0,5'd0, 4'b0000,1'b0};
        tv[3]  = '{1'b1,5'd3, 5'd3, 5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b1,5'd3, 1'b1,5'd3, 4'b0000,1'b0};
        tv[4]  = '{1'b0,5'd6, 5'd6, 5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b1,5'd6, 1'b1,5'd6, 4'b1010,1'b0};
        tv[5]  = '{1'b0,5'd8, 5'd9, 5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b1,5'd9, 1'b1,5'd8, 4'b1001,1'b0};
        tv[6]  = '{1'b0,5'd0, 5'd0, 5'd5, 5'd0, 2'b01,1'b1,5'd5,1'b0,5'd0, 1'b0,5'd0, 4'b0000,1'b1};
        tv[7]  = '{1'b0,5'd0, 5'd0, 5'd5, 5'd0, 2'b10,1'b1,5'd5,1'b0,5'd0, 1'b0,5'd0, 4'b0000,1'b0};
        tv[8]  = '{1'b0,5'd0, 5'd0, 5'd31,5'd0, 2'b01,1'b1,5'd31,1'b0,5'd0,1'b0,5'd0, 4'b0000,1'b0};
        tv[9]  = '{1'b0,5'd0, 5'd0, 5'd0, 5'd5, 2'b10,1'b1,5'd5,1'b0,5'd0, 1'b0,5'd0, 4'b0000,1'b1};
        tv[10] = '{1'b0,5'd0, 5'd0, 5'd0, 5'd5, 2'b10,1'b0,5'd5,1'b0,5'd0, 1'b0,5'd0, 4'b0000,1'b0};
        tv[11] = '{1'b0,5'd12,5'd0, 5'd0, 5'd0, 2'b00,1'b0,5'd0,1'b0,5'd12,1'b0,5'd12,4'b0000,1'b0};

        // Reset state
        do_reset();
        check("rst_busy", {31'd0, mc_busy}, 32'd0);
        check("rst_done", {31'd0, mc_done}, 32'd0);
        check("rst_cnt", {28'd0, stall_cycles}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_fwd", {28'd0, fwd_sel}, 32'd0);

        // Combinational vector table
        for (int i = 0; i < 12; i++) begin
            branching = tv[i].br; idex_src = {tv[i].xs1, tv[i].xs0};
            id_src = {tv[i].is1, tv[i].is0}; id_src_valid = tv[i].iv;
            idex_memread = tv[i].mr; idex_rd = tv[i].xrd;
            exmem_regwrite = tv[i].ew; exmem_rd = tv[i].erd;
            memwb_regwrite = tv[i].mw; memwb_rd = tv[i].mrd;
            #1;
            check($sformatf("vec%0d_fwd", i), {28'd0, fwd_sel}, {28'd0, tv[i].efwd});
            check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, tv[i].es});
            next_cycle();
        end

        // MC op: issue x7 at cycle 0, dependent reader and second issue wait for done
        do_reset();
        mc_issue = 1'b1; mc_rd = 5'd7; #1;
        check("mc_c0_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        mc_issue = 1'b0; id_src = {5'd0, 5'd7}; id_src_valid = 2'b01; idex_src = {5'd0, 5'd7}; #1;
        check("mc_c1_busy", {31'd0, mc_busy}, 32'd1);
        check("mc_c1_stall", {31'd0, stall}, 32'd1);
        check("mc_c1_done", {31'd0, mc_done}, 32'd0);
        next_cycle();
        mc_issue = 1'b1; mc_rd = 5'd9; #1;
        check("mc_c2_stall", {31'd0, stall}, 32'd1);
        next_cycle();
        check("mc_c3_stall", {31'd0, stall}, 32'd1);
        check("mc_c3_done", {31'd0, mc_done}, 32'd0);
        next_cycle();
        check("mc_c4_done", {31'd0, mc_done}, 32'd1);
        check("mc_c4_busy", {31'd0, mc_busy}, 32'd1);
        check("mc_c4_stall", {31'd0, stall}, 32'd0);
        check("mc_c4_fwd", {28'd0, fwd_sel}, 32'h3);
        check("mc_c4_cnt", {28'd0, stall_cycles}, 32'd3);
        next_cycle();
        mc_issue = 1'b0; id_src_valid = 2'b00; #1;
        check("mc_c5_busy", {31'd0, mc_busy}, 32'd1);
        check("mc_c5_done", {31'd0, mc_done}, 32'd0);
        check("mc_c5_fwd", {28'd0, fwd_sel}, 32'd0);
        next_cycle(); next_cycle();
        check("mc_c7_done", {31'd0, mc_done}, 32'd0);
        next_cycle();
        check("mc_c8_done", {31'd0, mc_done}, 32'd1);
        next_cycle();
        check("mc_c9_busy", {31'd0, mc_busy}, 32'd0);
        check("mc_c9_done", {31'd0, mc_done}, 32'd0);

        // Reset at cycle 2 of an MC op abandons it
        do_reset();
        mc_issue = 1'b1; mc_rd = 5'd7;
        next_cycle();
        mc_issue = 1'b0; id_src = {5'd0, 5'd7}; id_src_valid = 2'b01;
        next_cycle();
        check("rmid_pre_cnt", {28'd0, stall_cycles}, 32'd1);
        reset = 1'b1; #1;
        check("rmid_busy", {31'd0, mc_busy}, 32'd0);
        check("rmid_done", {31'd0, mc_done}, 32'd0);
        check("rmid_cnt", {28'd0, stall_cycles}, 32'd0);
        next_cycle();
        reset = 1'b0;
        seen_done = 1'b0; seen_busy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            seen_done = seen_done | mc_done;
            seen_busy = seen_busy | mc_busy;
        end
        check("rmid_no_done", {31'd0, seen_done}, 32'd0);
        check("rmid_no_busy", {31'd0, seen_busy}, 32'd0);

        // Stall counter saturation with CNT_W=4
        do_reset();
        idex_memread = 1'b1; idex_rd = 5'd5; id_src = {5'd0, 5'd5}; id_src_valid = 2'b01;
        for (int c = 0; c < 10; c++) next_cycle();
        check("sat_cnt10", {28'd0, stall_cycles}, 32'd10);
        for (int c = 0; c < 10; c++) next_cycle();
        check("sat_cnt20", {28'd0, stall_cycles}, 32'd15);
        id_src_valid = 2'b00;
        next_cycle();
        check("sat_hold", {28'd0, stall_cycles}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
